audio_i2s_tx: RTL and testbench

- I2S transmitter; the producer-side counterpart to the sample consumers on the audio path.
- Accepts stereo sample pairs in the team's padded audio-word format, {8'd0, signed 24-bit}, through a valid/ready handshake.
- Serialises them as standard Philips I2S: 64 BCLK per frame, 32-bit slots, MSB-first, data one BCLK after the LRCK edge.
- Generates BCLK and LRCK from sys_clk and drives the board DAC.

---
 rtl/audio_i2s_tx.sv | 125 ++++++++++++
 tb/tb_audio_i2s_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: 64 BCLK frames, 32-bit MSB-first slots, 24-bit left-justified samples.
// Optional macro I2S_TX_UNDERFLOW_HOLD_EN: on underflow repeat the last loaded pair instead of silence.
module audio_i2s_tx #(
  parameter int BCLK_DIV = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [31:0] left_in,
  input  logic [31:0] right_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        frame_start,
  output logic        underflow
);

  localparam int DW = $clog2(BCLK_DIV);

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_nxt;
  logic [4:0]    bit_idx;
  logic          tick, fall, load, xfer;
  logic          lrck_nxt, sdata_nxt;
  logic          holding_full;
  logic [23:0]   hold_l, hold_r;
  logic [31:0]   left_sh, right_sh;
  logic [31:0]   load_l, load_r;
  logic          unused_bits;

  assign unused_bits = ^{left_in[31:24], right_in[31:24]};

`ifdef I2S_TX_UNDERFLOW_HOLD_EN
  logic [23:0] shadow_l, shadow_r;
`endif

  assign sample_ready = ~holding_full;

  always_comb begin
    tick = (div_cnt == DW'(BCLK_DIV - 1));
    fall = tick && i2s_bclk;
    load = fall && (bit_cnt == 6'd63);
    xfer = sample_valid && ~holding_full;
    bit_nxt = bit_cnt + 6'd1;
    lrck_nxt = (bit_nxt >= 6'd31) && (bit_nxt <= 6'd62);
    if (holding_full) begin
      load_l = {hold_l, 8'd0};
      load_r = {hold_r, 8'd0};
    end else begin
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
      load_l = {shadow_l, 8'd0};
      load_r = {shadow_r, 8'd0};
`else
      load_l = '0;
      load_r = '0;
`endif
    end
    // Both slots index with 31-(n mod 32), which is the inverted low five bits.
    bit_idx = ~bit_nxt[4:0];
    if (load)
      sdata_nxt = load_l[31];
    else if (bit_nxt[5])
      sdata_nxt = right_sh[bit_idx];
    else
      sdata_nxt = left_sh[bit_idx];
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      i2s_bclk     <= 1'b0;
      i2s_lrck     <= 1'b0;
      i2s_sdata    <= 1'b0;
      holding_full <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      left_sh      <= '0;
      right_sh     <= '0;
      frame_start  <= 1'b0;
      underflow    <= 1'b0;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
      shadow_l     <= '0;
      shadow_r     <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      if (tick) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrck  <= lrck_nxt;
        i2s_sdata <= sdata_nxt;
      end
      if (load) begin
        left_sh     <= load_l;
        right_sh    <= load_r;
        frame_start <= 1'b1;
        underflow   <= ~holding_full;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
        if (holding_full) begin
          shadow_l <= hold_l;
          shadow_r <= hold_r;
        end
`endif
      end
      // A transfer can only coincide with a load when holding is empty.
      if (load && holding_full) begin
        holding_full <= 1'b0;
      end else if (xfer) begin
        holding_full <= 1'b1;
        hold_l       <= left_in[23:0];
        hold_r       <= right_in[23:0];
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx with BCLK_DIV=2, using a frame-level timing/content model.
module tb_audio_i2s_tx;

  localparam int D  = 2;
  localparam int FR = 128 * D;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] left_in = '0;
  logic [31:0] right_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underflow;

  audio_i2s_tx #(.BCLK_DIV(D)) dut (
    .sys_clk(sys_clk), .rst(rst), .left_in(left_in), .right_in(right_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .i2s_bclk(i2s_bclk),
    .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata), .frame_start(frame_start),
    .underflow(underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad = 0;

  // Model: k = sys_clk edges since reset release; frame content per loaded frame.
  int          k;
  bit          m_full, m_fs, m_uf, m_xfer;
  logic [31:0] m_hl, m_hr, m_cl, m_cr, m_sl, m_sr;
  logic [31:0] cap_l, cap_r;
  int          uf_seen, fs_seen, xfer_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic model_step();
    bit xfer;
    m_xfer = 1'b0;
    if (rst) begin
      k = 0; m_full = 0; m_fs = 0; m_uf = 0;
      m_cl = '0; m_cr = '0; m_sl = '0; m_sr = '0;
    end else begin
      k++;
      m_fs = 0; m_uf = 0;
      xfer = sample_valid && !m_full;
      if (k % FR == 0) begin
        m_fs = 1;
        if (m_full) begin
          m_cl = m_hl; m_cr = m_hr; m_sl = m_hl; m_sr = m_hr; m_full = 0;
        end else begin
          m_uf = 1;
`ifdef I2S_TX_UNDERFLOW_HOLD_EN
          m_cl = m_sl; m_cr = m_sr;
`else
          m_cl = '0; m_cr = '0;
`endif
        end
      end
      if (xfer) begin
        m_full = 1;
        m_hl = {left_in[23:0], 8'h00};
        m_hr = {right_in[23:0], 8'h00};
        m_xfer = 1;
      end
    end
  endtask

  task automatic compare();
    int bc;
    logic e_sd;
    bc = (k / (2 * D)) % 64;
    e_sd = (bc < 32) ? m_cl[31 - bc] : m_cr[63 - bc];
    chk("bclk", {31'd0, i2s_bclk}, {31'd0, 1'((k / D) % 2)});
    chk("lrck", {31'd0, i2s_lrck}, {31'd0, (bc >= 31 && bc <= 62)});
    chk("sdata", {31'd0, i2s_sdata}, {31'd0, e_sd});
    chk("ready", {31'd0, sample_ready}, {31'd0, !m_full});
    chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
    if (underflow) uf_seen++;
    if (frame_start) fs_seen++;
    if (!rst && (k % (2 * D) == D)) begin
      if (bc < 32) cap_l[31 - bc] = i2s_sdata;
      else         cap_r[63 - bc] = i2s_sdata;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    compare();
  endtask

  task automatic send(input logic [31:0] l, input logic [31:0] r, input string name);
    int n;
    left_in = l; right_in = r; sample_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!m_xfer && n < 2 * FR);
    sample_valid = 1'b0;
    chk({name, "_accept"}, {31'd0, m_xfer}, 32'd1);
  endtask

  initial begin
    int n;
    int p;
    repeat (3) tick();
    rst = 1'b0;

    // Idle: two underflowing loads in the first 2 frames
    uf_seen = 0;
    repeat (2 * FR + 2) tick();
    chk("idle_underflows", uf_seen, 2);

    // Single pair, read back bit-by-bit on BCLK rising edges
    send(32'h00A5_5A5A, 32'h0080_0001, "a5");
    n = 0;
    while (!m_fs && n < 2 * FR) begin tick(); n++; end
    chk("a5_load_seen", {31'd0, m_fs}, 32'd1);
    chk("a5_frame_start", {31'd0, frame_start}, 32'd1);
    chk("a5_no_underflow", {31'd0, underflow}, 32'd0);
    repeat (FR - 1) tick();
    chk("a5_left_word", cap_l, 32'hA55A_5A00);
    chk("a5_right_word", cap_r, 32'h8000_0100);

    // Continuous stream, one transfer per frame, upper byte garbage ignored
    tick();
    uf_seen = 0; fs_seen = 0; xfer_cnt = 0; p = 1;
    sample_valid = 1'b1;
    repeat (4 * FR) begin
      left_in  = {8'hFF, 24'(p)};
      right_in = {8'hC3, 24'(p * 3)};
      tick();
      if (m_xfer) begin p++; xfer_cnt++; end
    end
    sample_valid = 1'b0;
    chk("stream_no_underflow", uf_seen, 0);
    chk("stream_loads", fs_seen, 4);
    chk("stream_xfers", xfer_cnt, 4);

    // Starved: every frame underflows (repeat or silence checked by the model)
    uf_seen = 0;
    repeat (2 * FR) tick();
    chk("starve_underflows", uf_seen, 2);

    // First valid lands exactly on the load-event cycle
    n = 0;
    while (((k + 1) % FR) != 0 && n < 2 * FR) begin tick(); n++; end
    left_in = 32'h0012_3456; right_in = 32'h00FE_DCBA; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("late_xfer", {31'd0, m_xfer}, 32'd1);
    chk("late_underflow", {31'd0, underflow}, 32'd1);
    chk("late_ready_low", {31'd0, sample_ready}, 32'd0);
    repeat (2 * FR - 1) tick();
    chk("late_left_word", cap_l, 32'h1234_5600);
    chk("late_right_word", cap_r, 32'hFEDC_BA00);

    // Reset in the right slot with holding full
    send(32'h0011_1111, 32'h0022_2222, "rst");
    n = 0;
    while (((k / (2 * D)) % 64) != 45 && n < 2 * FR) begin tick(); n++; end
    chk("rst_reach45", {31'd0, ((k / (2 * D)) % 64) == 45}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_bclk", {31'd0, i2s_bclk}, 32'd0);
    chk("rst_lrck", {31'd0, i2s_lrck}, 32'd0);
    chk("rst_sdata", {31'd0, i2s_sdata}, 32'd0);
    chk("rst_ready", {31'd0, sample_ready}, 32'd1);
    rst = 1'b0;
    uf_seen = 0; fs_seen = 0;
    repeat (FR + 2) tick();
    chk("post_rst_underflow", uf_seen, 1);
    chk("post_rst_load", fs_seen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
